// File: rtl/mipi_csi_pkg.sv
`timescale 1ns/1ps
// Shared CSI-2 receive definitions: short/long packet data types, controller states
// and the header data-type classifier used by the frame controller.
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FRAME    = 3'd1,
        ST_LONG_PKT = 3'd2,
        ST_WAIT_CRC = 3'd3,
        ST_DROP     = 3'd4
    } csi_state_e;

    typedef enum logic [2:0] {
        PKT_FS,
        PKT_FE,
        PKT_LS,
        PKT_LE,
        PKT_LONG,
        PKT_RSVD
    } pkt_kind_e;

    // 0x04-0x0F are reserved/generic short packets and are never acted on.
    function automatic pkt_kind_e classify_dt(input logic [5:0] dt);
        pkt_kind_e kind;
        if (dt >= DT_LONG_MIN)  kind = PKT_LONG;
        else if (dt == DT_FS)   kind = PKT_FS;
        else if (dt == DT_FE)   kind = PKT_FE;
        else if (dt == DT_LS)   kind = PKT_LS;
        else if (dt == DT_LE)   kind = PKT_LE;
        else                    kind = PKT_RSVD;
        return kind;
    endfunction

endpackage

// File: rtl/mipi_csi_sat_counter.sv
`timescale 1ns/1ps
// 8-bit saturating event counter; a clear request wins over a coincident increment.
module mipi_csi_sat_counter (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic [7:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= 8'd0;
        end else if (clear_i) begin
            count_o <= 8'd0;
        end else if (inc_i && (count_o != 8'hFF)) begin
            count_o <= count_o + 8'd1;
        end
    end

endmodule

// File: rtl/mipi_csi_rx_frame_controller.sv
`timescale 1ns/1ps
// CSI-2 receive frame controller: tracks FS/FE framing on one virtual channel, gates
// long-packet payload, checks CRC completion and line counts, and counts ECC/CRC errors.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | no frame open, waiting for FS on an enabled VC
// ST_FRAME    | frame open on frame_vc_o, between packets
// ST_LONG_PKT | long packet payload streaming, payload_accept_o high
// ST_WAIT_CRC | payload finished, waiting up to CRC_TIMEOUT cycles for CRC result
// ST_DROP     | frame corrupted, discarding until FE/FS on frame_vc_o
module mipi_csi_rx_frame_controller #(
    parameter int CRC_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        header_valid_i,
    input  logic [1:0]  vc_id_i,
    input  logic [5:0]  data_type_i,
    input  logic [15:0] packet_length_i,
    input  logic        header_error_i,
    input  logic        payload_done_i,
    input  logic        crc_valid_i,
    input  logic        crc_error_i,
    input  logic [3:0]  vc_enable_i,
    input  logic [15:0] expected_lines_i,
    input  logic        cnt_clear_i,
    output logic        frame_valid_o,
    output logic        line_valid_o,
    output logic        payload_accept_o,
    output logic        drop_o,
    output logic [1:0]  frame_vc_o,
    output logic [15:0] line_count_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        err_frame_sync_o,
    output logic        err_line_count_o,
    output logic [7:0]  err_crc_count_o,
    output logic [7:0]  err_ecc_count_o
);
    import mipi_csi_pkg::*;

    localparam int TW = $clog2(CRC_TIMEOUT + 1);

    csi_state_e  state_q, state_d;
    pkt_kind_e   kind;
    logic [1:0]  vc_d;
    logic [15:0] lc_d, lc_inc, exp_q, exp_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        fs_p, fe_p, sync_p, lerr_p;
    logic        hdr_ok, vc_match, ecc_inc, crc_inc;

    assign hdr_ok   = header_valid_i & ~header_error_i;
    assign kind     = classify_dt(data_type_i);
    assign vc_match = (vc_id_i == frame_vc_o);
    assign lc_inc   = (line_count_o == 16'hFFFF) ? line_count_o : line_count_o + 16'd1;
    assign ecc_inc  = header_valid_i & header_error_i;
    assign crc_inc  = (state_q == ST_WAIT_CRC) & crc_valid_i & crc_error_i;

    always_comb begin
        state_d = state_q;
        vc_d    = frame_vc_o;
        lc_d    = line_count_o;
        exp_d   = exp_q;
        timer_d = timer_q;
        fs_p    = 1'b0;
        fe_p    = 1'b0;
        sync_p  = 1'b0;
        lerr_p  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hdr_ok && vc_enable_i[vc_id_i] && (kind != PKT_RSVD)) begin
                    if (kind == PKT_FS) fs_p = 1'b1;
                    else                sync_p = 1'b1;
                end
            end
            ST_FRAME: begin
                if (hdr_ok && vc_match) begin
                    case (kind)
                        PKT_FS: begin
                            fs_p   = 1'b1;
                            sync_p = 1'b1;
                        end
                        PKT_FE: begin
                            state_d = ST_IDLE;
                            fe_p    = 1'b1;
                            lerr_p  = (exp_q != 16'd0) && (line_count_o != exp_q);
                        end
                        PKT_LONG: begin
                            if (packet_length_i == 16'd0) lc_d = lc_inc;
                            else                          state_d = ST_LONG_PKT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LONG_PKT: begin
                sync_p = hdr_ok && (kind != PKT_RSVD);
                if (payload_done_i) begin
                    state_d = ST_WAIT_CRC;
                    timer_d = TW'(CRC_TIMEOUT);
                end
            end
            ST_WAIT_CRC: begin
                sync_p = hdr_ok && (kind != PKT_RSVD);
                if (crc_valid_i) begin
                    if (crc_error_i) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_FRAME;
                        lc_d    = lc_inc;
                    end
                end else if (timer_q < TW'(2)) begin
                    state_d = ST_DROP;
                    sync_p  = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DROP: begin
                if (hdr_ok && vc_match) begin
                    if (kind == PKT_FS) begin
                        fs_p = 1'b1;
                    end else if (kind == PKT_FE) begin
                        state_d = ST_IDLE;
                        fe_p    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Every accepted FS opens a fresh frame; line target is sampled only here.
        if (fs_p) begin
            state_d = ST_FRAME;
            vc_d    = vc_id_i;
            lc_d    = 16'd0;
            exp_d   = expected_lines_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= ST_IDLE;
            frame_vc_o       <= 2'd0;
            line_count_o     <= 16'd0;
            exp_q            <= 16'd0;
            timer_q          <= '0;
            frame_valid_o    <= 1'b0;
            line_valid_o     <= 1'b0;
            payload_accept_o <= 1'b0;
            drop_o           <= 1'b0;
            frame_start_o    <= 1'b0;
            frame_end_o      <= 1'b0;
            err_frame_sync_o <= 1'b0;
            err_line_count_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            frame_vc_o       <= vc_d;
            line_count_o     <= lc_d;
            exp_q            <= exp_d;
            timer_q          <= timer_d;
            frame_valid_o    <= (state_d == ST_FRAME) || (state_d == ST_LONG_PKT) ||
                                (state_d == ST_WAIT_CRC);
            line_valid_o     <= (state_d == ST_LONG_PKT);
            payload_accept_o <= (state_d == ST_LONG_PKT);
            drop_o           <= (state_d == ST_DROP);
            frame_start_o    <= fs_p;
            frame_end_o      <= fe_p;
            err_frame_sync_o <= sync_p;
            err_line_count_o <= lerr_p;
        end
    end

    mipi_csi_sat_counter u_crc_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (cnt_clear_i),
        .inc_i     (crc_inc),
        .count_o   (err_crc_count_o)
    );

    mipi_csi_sat_counter u_ecc_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (cnt_clear_i),
        .inc_i     (ecc_inc),
        .count_o   (err_ecc_count_o)
    );

endmodule

// File: tb/tb_mipi_csi_rx_frame_controller.sv
`timescale 1ns/1ps
// Randomized self-checking bench for mipi_csi_rx_frame_controller with a
// transaction-level frame model (lines per frame, drop status, error counters).
module tb_mipi_csi_rx_frame_controller;

    localparam logic [5:0] T_FS = 6'h00;
    localparam logic [5:0] T_FE = 6'h01;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        header_valid_i = 1'b0;
    logic [1:0]  vc_id_i = 2'd0;
    logic [5:0]  data_type_i = 6'd0;
    logic [15:0] packet_length_i = 16'd0;
    logic        header_error_i = 1'b0;
    logic        payload_done_i = 1'b0;
    logic        crc_valid_i = 1'b0;
    logic        crc_error_i = 1'b0;
    logic [3:0]  vc_enable_i = 4'd0;
    logic [15:0] expected_lines_i = 16'd0;
    logic        cnt_clear_i = 1'b0;
    logic        frame_valid_o, line_valid_o, payload_accept_o, drop_o;
    logic [1:0]  frame_vc_o;
    logic [15:0] line_count_o;
    logic        frame_start_o, frame_end_o, err_frame_sync_o, err_line_count_o;
    logic [7:0]  err_crc_count_o, err_ecc_count_o;

    int n_chk = 0;
    int n_pass = 0;
    int exp_crc = 0;
    int exp_ecc = 0;
    int c_fs = 0, c_fe = 0, c_sync = 0, c_lerr = 0;

    mipi_csi_rx_frame_controller #(.CRC_TIMEOUT(16)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .header_valid_i   (header_valid_i),
        .vc_id_i          (vc_id_i),
        .data_type_i      (data_type_i),
        .packet_length_i  (packet_length_i),
        .header_error_i   (header_error_i),
        .payload_done_i   (payload_done_i),
        .crc_valid_i      (crc_valid_i),
        .crc_error_i      (crc_error_i),
        .vc_enable_i      (vc_enable_i),
        .expected_lines_i (expected_lines_i),
        .cnt_clear_i      (cnt_clear_i),
        .frame_valid_o    (frame_valid_o),
        .line_valid_o     (line_valid_o),
        .payload_accept_o (payload_accept_o),
        .drop_o           (drop_o),
        .frame_vc_o       (frame_vc_o),
        .line_count_o     (line_count_o),
        .frame_start_o    (frame_start_o),
        .frame_end_o      (frame_end_o),
        .err_frame_sync_o (err_frame_sync_o),
        .err_line_count_o (err_line_count_o),
        .err_crc_count_o  (err_crc_count_o),
        .err_ecc_count_o  (err_ecc_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse tallies; a pulse stuck high is counted once per cycle.
    always @(negedge clk_i) begin
        c_fs   = c_fs + int'(frame_start_o);
        c_fe   = c_fe + int'(frame_end_o);
        c_sync = c_sync + int'(err_frame_sync_o);
        c_lerr = c_lerr + int'(err_line_count_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] len,
                       input logic err);
        vc_id_i = vc; data_type_i = dt; packet_length_i = len; header_error_i = err;
        header_valid_i = 1'b1;
        step();
        header_valid_i = 1'b0; header_error_i = 1'b0;
    endtask

    task automatic send_long(input logic [1:0] vc, input logic [15:0] len, input logic crc_err,
                             output logic acc);
        hdr(vc, 6'($urandom_range(16, 63)), len, 1'b0);
        acc = payload_accept_o;
        repeat ($urandom_range(0, 3)) step();
        payload_done_i = 1'b1; step(); payload_done_i = 1'b0;
        repeat ($urandom_range(0, 4)) step();
        crc_valid_i = 1'b1; crc_error_i = crc_err; step();
        crc_valid_i = 1'b0; crc_error_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; vc_enable_i = 4'b0001;
        repeat (3) step();
        n_chk++; if ({frame_valid_o, line_valid_o, payload_accept_o, drop_o, frame_start_o, frame_end_o, err_frame_sync_o, err_line_count_o} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000", {frame_valid_o, line_valid_o, payload_accept_o, drop_o, frame_start_o, frame_end_o, err_frame_sync_o, err_line_count_o}); else n_pass++;
        n_chk++; if ({frame_vc_o, line_count_o, err_crc_count_o, err_ecc_count_o} !== 34'd0)
            $display("FAIL reset_values: got %h want 0", {frame_vc_o, line_count_o, err_crc_count_o, err_ecc_count_o}); else n_pass++;
        reset_n_i = 1'b1;
        step();
        hdr(2'd0, 6'h2A, 16'd16, 1'b0);
        n_chk++; if (payload_accept_o !== 1'b0) $display("FAIL accept_before_fs: got %b want 0", payload_accept_o); else n_pass++;
        n_chk++; if (err_frame_sync_o !== 1'b1) $display("FAIL idle_long_sync: got %b want 1", err_frame_sync_o); else n_pass++;
        step();
        n_chk++; if (err_frame_sync_o !== 1'b0) $display("FAIL sync_one_cycle: got %b want 0", err_frame_sync_o); else n_pass++;
    endtask

    task automatic test_good_frame();
        int b_fs, b_fe, b_sync, b_lerr;
        b_fs = c_fs; b_fe = c_fe; b_sync = c_sync; b_lerr = c_lerr;
        vc_enable_i = 4'b0001; expected_lines_i = 16'd3;
        hdr(2'd0, T_FS, 16'd0, 1'b0);
        n_chk++; if ({frame_valid_o, frame_start_o} !== 2'b11) $display("FAIL good_fs: got %b want 11", {frame_valid_o, frame_start_o}); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            hdr(2'd0, 6'h2A, 16'd64, 1'b0);
            n_chk++; if ({line_valid_o, payload_accept_o} !== 2'b11) $display("FAIL good_accept%0d: got %b want 11", i, {line_valid_o, payload_accept_o}); else n_pass++;
            repeat (2) step();
            payload_done_i = 1'b1; step(); payload_done_i = 1'b0;
            n_chk++; if ({line_valid_o, payload_accept_o, frame_valid_o} !== 3'b001) $display("FAIL good_done%0d: got %b want 001", i, {line_valid_o, payload_accept_o, frame_valid_o}); else n_pass++;
            step();
            crc_valid_i = 1'b1; step(); crc_valid_i = 1'b0;
            n_chk++; if (line_count_o !== 16'(i + 1)) $display("FAIL good_lines%0d: got %0d want %0d", i, line_count_o, i + 1); else n_pass++;
        end
        hdr(2'd0, T_FE, 16'd0, 1'b0);
        n_chk++; if ({frame_end_o, frame_valid_o, err_line_count_o} !== 3'b100) $display("FAIL good_fe: got %b want 100", {frame_end_o, frame_valid_o, err_line_count_o}); else n_pass++;
        step();
        n_chk++; if ({c_fs - b_fs, c_fe - b_fe, c_sync - b_sync, c_lerr - b_lerr} !== {32'd1, 32'd1, 32'd0, 32'd0})
            $display("FAIL good_pulses: got fs=%0d fe=%0d sync=%0d lerr=%0d want 1 1 0 0", c_fs - b_fs, c_fe - b_fe, c_sync - b_sync, c_lerr - b_lerr); else n_pass++;
        n_chk++; if ({err_crc_count_o, err_ecc_count_o} !== {8'(exp_crc), 8'(exp_ecc)}) $display("FAIL good_counters: got %0d/%0d want %0d/%0d", err_crc_count_o, err_ecc_count_o, exp_crc, exp_ecc); else n_pass++;
    endtask

    task automatic test_crc_error();
        logic acc;
        int b_fe;
        vc_enable_i = 4'b0001; expected_lines_i = 16'd3;
        hdr(2'd0, T_FS, 16'd0, 1'b0);
        send_long(2'd0, 16'd64, 1'b0, acc);
        send_long(2'd0, 16'd64, 1'b1, acc);
        exp_crc = sat8(exp_crc + 1);
        n_chk++; if ({drop_o, frame_valid_o} !== 2'b10) $display("FAIL crc_drop: got %b want 10", {drop_o, frame_valid_o}); else n_pass++;
        n_chk++; if (err_crc_count_o !== 8'(exp_crc)) $display("FAIL crc_count: got %0d want %0d", err_crc_count_o, exp_crc); else n_pass++;
        n_chk++; if (line_count_o !== 16'd1) $display("FAIL crc_lines: got %0d want 1", line_count_o); else n_pass++;
        hdr(2'd0, 6'h2A, 16'd64, 1'b0);
        n_chk++; if ({drop_o, payload_accept_o} !== 2'b10) $display("FAIL drop_ignores_pkt: got %b want 10", {drop_o, payload_accept_o}); else n_pass++;
        b_fe = c_fe;
        hdr(2'd0, T_FE, 16'd0, 1'b0);
        n_chk++; if ({frame_end_o, drop_o, err_line_count_o} !== 3'b100) $display("FAIL drop_fe: got %b want 100", {frame_end_o, drop_o, err_line_count_o}); else n_pass++;
        hdr(2'd0, T_FS, 16'd0, 1'b0);
        n_chk++; if ({frame_valid_o, frame_start_o, drop_o} !== 3'b110) $display("FAIL recover_fs: got %b want 110", {frame_valid_o, frame_start_o, drop_o}); else n_pass++;
        send_long(2'd0, 16'd64, 1'b0, acc);
        n_chk++; if ({acc, line_count_o} !== {1'b1, 16'd1}) $display("FAIL recover_pkt: got %b/%0d want 1/1", acc, line_count_o); else n_pass++;
        hdr(2'd0, T_FE, 16'd0, 1'b0);
        step();
        n_chk++; if (c_fe - b_fe !== 2) $display("FAIL crc_fe_count: got %0d want 2", c_fe - b_fe); else n_pass++;
    endtask

    task automatic test_sync_errors();
        int b_fs, b_fe, b_sync;
        vc_enable_i = 4'b0001; expected_lines_i = 16'd0;
        b_fs = c_fs; b_fe = c_fe; b_sync = c_sync;
        hdr(2'd0, T_FE, 16'd0, 1'b0);
        n_chk++; if ({err_frame_sync_o, frame_end_o, frame_valid_o} !== 3'b100) $display("FAIL idle_fe: got %b want 100", {err_frame_sync_o, frame_end_o, frame_valid_o}); else n_pass++;
        hdr(2'd0, T_FS, 16'd0, 1'b0);
        n_chk++; if ({frame_start_o, err_frame_sync_o, frame_valid_o} !== 3'b101) $display("FAIL first_fs: got %b want 101", {frame_start_o, err_frame_sync_o, frame_valid_o}); else n_pass++;
        hdr(2'd0, 6'h30, 16'd0, 1'b0);
        hdr(2'd0, T_FS, 16'd0, 1'b0);
        n_chk++; if ({frame_start_o, err_frame_sync_o, frame_valid_o, line_count_o} !== {3'b111, 16'd0}) $display("FAIL second_fs: got %b/%0d want 111/0", {frame_start_o, err_frame_sync_o, frame_valid_o}, line_count_o); else n_pass++;
        step();
        n_chk++; if ({c_fs - b_fs, c_fe - b_fe, c_sync - b_sync} !== {32'd2, 32'd0, 32'd2}) $display("FAIL sync_pulses: got fs=%0d fe=%0d sync=%0d want 2 0 2", c_fs - b_fs, c_fe - b_fe, c_sync - b_sync); else n_pass++;
        hdr(2'd0, T_FE, 16'd0, 1'b0);
    endtask

    task automatic test_crc_timeout();
        int drop_at, sync_at;
        vc_enable_i = 4'b0001; expected_lines_i = 16'd0;
        hdr(2'd0, T_FS, 16'd0, 1'b0);
        hdr(2'd0, 6'h2A, 16'd32, 1'b0);
        step();
        payload_done_i = 1'b1; step(); payload_done_i = 1'b0;
        drop_at = 0; sync_at = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (drop_o && drop_at == 0) drop_at = k;
            if (err_frame_sync_o && sync_at == 0) sync_at = k;
        end
        n_chk++; if (drop_at !== 16) $display("FAIL timeout_drop_cycle: got %0d want 16", drop_at); else n_pass++;
        n_chk++; if (sync_at !== 16) $display("FAIL timeout_sync_cycle: got %0d want 16", sync_at); else n_pass++;
        hdr(2'd0, T_FE, 16'd0, 1'b0);
        n_chk++; if ({frame_end_o, drop_o} !== 2'b10) $display("FAIL timeout_fe: got %b want 10", {frame_end_o, drop_o}); else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) begin
            logic [1:0]  vc;
            logic [15:0] len;
            logic        m_drop, acc, want_lerr;
            int          n, err_idx, m_lines, b_sync, r;
            vc = 2'($urandom_range(0, 3));
            vc_enable_i = 4'($urandom_range(0, 15)) | (4'b0001 << vc);
            expected_lines_i = 16'($urandom_range(0, 5));
            n = $urandom_range(1, 5);
            err_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            b_sync = c_sync;
            hdr(vc, T_FS, 16'd0, 1'b0);
            n_chk++; if ({frame_valid_o, frame_vc_o} !== {1'b1, vc}) $display("FAIL rnd_fs f%0d: got %b/%0d want 1/%0d", f, frame_valid_o, frame_vc_o, vc); else n_pass++;
            m_lines = 0; m_drop = 1'b0;
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 5);
                if (r == 0) hdr(vc + 2'd1, 6'($urandom_range(0, 63)), 16'($urandom_range(0, 9)), 1'b0);
                else if (r == 1) hdr(vc, 6'($urandom_range(4, 15)), 16'd5, 1'b0);
                else if (r == 2) begin
                    hdr(vc, 6'($urandom_range(0, 63)), 16'd7, 1'b1);
                    exp_ecc = sat8(exp_ecc + 1);
                end
                len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 200));
                if (m_drop) begin
                    hdr(vc, 6'($urandom_range(16, 63)), len, 1'b0);
                    n_chk++; if ({drop_o, payload_accept_o} !== 2'b10) $display("FAIL rnd_drop f%0d k%0d: got %b want 10", f, k, {drop_o, payload_accept_o}); else n_pass++;
                end else if (len == 16'd0) begin
                    hdr(vc, 6'($urandom_range(16, 63)), 16'd0, 1'b0);
                    m_lines++;
                end else begin
                    send_long(vc, len, k == err_idx, acc);
                    n_chk++; if (acc !== 1'b1) $display("FAIL rnd_accept f%0d k%0d: got %b want 1", f, k, acc); else n_pass++;
                    if (k == err_idx) begin
                        m_drop = 1'b1;
                        exp_crc = sat8(exp_crc + 1);
                    end else m_lines++;
                end
                n_chk++; if ({line_count_o, drop_o} !== {16'(m_lines), m_drop}) $display("FAIL rnd_state f%0d k%0d: got lines=%0d drop=%b want lines=%0d drop=%b", f, k, line_count_o, drop_o, m_lines, m_drop); else n_pass++;
            end
            want_lerr = !m_drop && (expected_lines_i != 16'd0) && (m_lines != int'(expected_lines_i));
            hdr(vc, T_FE, 16'd0, 1'b0);
            n_chk++; if ({frame_end_o, frame_valid_o, drop_o, err_line_count_o} !== {3'b100, want_lerr}) $display("FAIL rnd_fe f%0d: got %b want %b", f, {frame_end_o, frame_valid_o, drop_o, err_line_count_o}, {3'b100, want_lerr}); else n_pass++;
            n_chk++; if ({err_crc_count_o, err_ecc_count_o} !== {8'(exp_crc), 8'(exp_ecc)}) $display("FAIL rnd_counters f%0d: got %0d/%0d want %0d/%0d", f, err_crc_count_o, err_ecc_count_o, exp_crc, exp_ecc); else n_pass++;
            step();
            n_chk++; if (c_sync - b_sync !== 0) $display("FAIL rnd_sync f%0d: got %0d want 0", f, c_sync - b_sync); else n_pass++;
        end
    endtask

    task automatic test_counter_sat();
        vc_enable_i = 4'b0001; expected_lines_i = 16'd0;
        hdr(2'd0, T_FS, 16'd0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            hdr(2'd0, 6'($urandom_range(0, 63)), 16'd3, 1'b1);
            exp_ecc = sat8(exp_ecc + 1);
        end
        n_chk++; if (err_ecc_count_o !== 8'(exp_ecc)) $display("FAIL ecc_sat: got %0d want %0d", err_ecc_count_o, exp_ecc); else n_pass++;
        cnt_clear_i = 1'b1;
        hdr(2'd0, 6'h2A, 16'd3, 1'b1);
        cnt_clear_i = 1'b0;
        exp_ecc = 0; exp_crc = 0;
        n_chk++; if ({err_ecc_count_o, err_crc_count_o} !== 16'd0) $display("FAIL ecc_clear_wins: got %0d/%0d want 0/0", err_ecc_count_o, err_crc_count_o); else n_pass++;
        for (int i = 0; i < 257; i++) begin
            hdr(2'd0, 6'h2A, 16'd8, 1'b0);
            payload_done_i = 1'b1; step(); payload_done_i = 1'b0;
            crc_valid_i = 1'b1; crc_error_i = 1'b1; step(); crc_valid_i = 1'b0; crc_error_i = 1'b0;
            exp_crc = sat8(exp_crc + 1);
            if (i == 254) begin
                n_chk++; if (err_crc_count_o !== 8'd255) $display("FAIL crc_reach_255: got %0d want 255", err_crc_count_o); else n_pass++;
            end
            hdr(2'd0, T_FS, 16'd0, 1'b0);
        end
        n_chk++; if ({err_crc_count_o, err_ecc_count_o} !== {8'(exp_crc), 8'd0}) $display("FAIL crc_sat: got %0d/%0d want %0d/0", err_crc_count_o, err_ecc_count_o, exp_crc); else n_pass++;
        hdr(2'd0, 6'h2A, 16'd8, 1'b0);
        payload_done_i = 1'b1; step(); payload_done_i = 1'b0;
        cnt_clear_i = 1'b1; crc_valid_i = 1'b1; crc_error_i = 1'b1; step();
        cnt_clear_i = 1'b0; crc_valid_i = 1'b0; crc_error_i = 1'b0;
        exp_crc = 0;
        n_chk++; if ({err_crc_count_o, drop_o} !== {8'd0, 1'b1}) $display("FAIL crc_clear_wins: got %0d/%b want 0/1", err_crc_count_o, drop_o); else n_pass++;
        hdr(2'd0, T_FE, 16'd0, 1'b0);
        n_chk++; if ({frame_end_o, drop_o, frame_valid_o} !== 3'b100) $display("FAIL sat_fe: got %b want 100", {frame_end_o, drop_o, frame_valid_o}); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        vc_enable_i = 4'b0100; expected_lines_i = 16'd0;
        hdr(2'd2, T_FS, 16'd0, 1'b0);
        hdr(2'd2, 6'h20, 16'd0, 1'b0);
        hdr(2'd2, 6'h20, 16'd0, 1'b1);
        exp_ecc = sat8(exp_ecc + 1);
        hdr(2'd2, 6'h2B, 16'd100, 1'b0);
        n_chk++; if ({payload_accept_o, frame_vc_o, line_count_o, err_ecc_count_o} !== {1'b1, 2'd2, 16'd1, 8'(exp_ecc)}) $display("FAIL pre_reset: got %b/%0d/%0d/%0d want 1/2/1/%0d", payload_accept_o, frame_vc_o, line_count_o, err_ecc_count_o, exp_ecc); else n_pass++;
        #2 reset_n_i = 1'b0;
        #1;
        exp_ecc = 0; exp_crc = 0;
        n_chk++; if ({frame_valid_o, line_valid_o, payload_accept_o, drop_o} !== 4'b0000) $display("FAIL async_reset_flags: got %b want 0000", {frame_valid_o, line_valid_o, payload_accept_o, drop_o}); else n_pass++;
        n_chk++; if ({frame_vc_o, line_count_o, err_ecc_count_o, err_crc_count_o} !== 34'd0) $display("FAIL async_reset_values: got %h want 0", {frame_vc_o, line_count_o, err_ecc_count_o, err_crc_count_o}); else n_pass++;
        step();
        reset_n_i = 1'b1;
        step();
        hdr(2'd2, 6'h2B, 16'd100, 1'b0);
        n_chk++; if ({payload_accept_o, err_frame_sync_o} !== 2'b01) $display("FAIL post_reset_needs_fs: got %b want 01", {payload_accept_o, err_frame_sync_o}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_sync_errors();
        test_crc_timeout();
        test_random_frames();
        test_counter_sat();
        test_reset_mid_packet();
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
